uart_rx_ctrl: RTL and testbench

- Receive-path sequencer for the UART RX.
- Detects the start edge and owns the per-bit edge counter and bit counter.
- Drives the majority-vote sampler's enable and edge_counter inputs, and strobes the deserializer once per data bit.
- Checks start, parity and stop bits, then issues a one-cycle data_valid or error flags per frame.

---
 rtl/uart_rx_ctrl.sv | 224 ++++++++++++++++++++++
 tb/tb_uart_rx_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_ctrl.sv
// UART receive sequencer: start detection, per-bit edge/bit counting, parity and stop checks.
// Optional break detection is compiled in with UART_RX_BREAK_DET_EN.
//
//   state    | meaning
//   ---------+---------------------------------------------------------------
//   S_IDLE   | line idle, waiting for a low level (and prescale >= 8)
//   S_START  | start bit; confirmed low at bit end or rejected as a glitch
//   S_DATA   | DATA_WIDTH data bits, one deserializer strobe per bit end
//   S_PARITY | optional parity bit, compared against the running XOR
//   S_STOP   | stop bit; frame result registered into the following IDLE cycle
module uart_rx_ctrl #(
    parameter int PWIDTH     = 6,
    parameter int DATA_WIDTH = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_in,
    input  logic [PWIDTH-1:0] prescale,
    input  logic              par_en,
    input  logic              par_typ,
    input  logic              sampled_bit,
    output logic [PWIDTH-1:0] edge_count,
    output logic              dat_samp_en,
    output logic              deser_en,
    output logic              data_valid,
    output logic              par_err,
    output logic              stp_err,
    output logic              strt_glitch,
    output logic              busy,
    output logic              break_det
);

    localparam int                BWIDTH       = 4;
    localparam logic [PWIDTH-1:0] PRESCALE_MIN = PWIDTH'(8);
    localparam logic [BWIDTH-1:0] LAST_BIT     = BWIDTH'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t state_q, state_d;

    logic [PWIDTH-1:0] edge_q;
    logic [PWIDTH-1:0] prescale_q;
    logic [BWIDTH-1:0] bit_cnt_q;
    logic              par_acc_q;
    logic              perr_q;
    logic              valid_q;
    logic              par_err_q;
    logic              stp_err_q;

    logic bit_end;
    logic stop_end;
    logic start_go;
    logic start_ok;
    logic is_break;
    logic deser_d;
    logic glitch_d;

    assign bit_end  = (state_q != S_IDLE) && (edge_q == prescale_q - PWIDTH'(1));
    assign stop_end = (state_q == S_STOP) && bit_end;

    always_comb begin
        state_d  = state_q;
        start_go = 1'b0;
        deser_d  = 1'b0;
        glitch_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (!rx_in && start_ok && (prescale >= PRESCALE_MIN)) begin
                    start_go = 1'b1;
                    state_d  = S_START;
                end
            end
            S_START: begin
                if (bit_end) begin
                    if (!sampled_bit) begin
                        state_d = S_DATA;
                    end else begin
                        glitch_d = 1'b1;
                        state_d  = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (bit_end) begin
                    deser_d = 1'b1;
                    if (bit_cnt_q == LAST_BIT) begin
                        state_d = par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                if (bit_end) begin
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (bit_end) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            edge_q     <= '0;
            prescale_q <= '0;
            bit_cnt_q  <= '0;
            par_acc_q  <= 1'b0;
            perr_q     <= 1'b0;
        end else begin
            if ((state_q == S_IDLE) || bit_end) begin
                edge_q <= '0;
            end else begin
                edge_q <= edge_q + PWIDTH'(1);
            end

            if (start_go) begin
                prescale_q <= prescale;
            end

            if ((state_q == S_DATA) && bit_end) begin
                bit_cnt_q <= (bit_cnt_q == LAST_BIT) ? '0 : bit_cnt_q + BWIDTH'(1);
            end

            if (start_go || stop_end) begin
                par_acc_q <= 1'b0;
            end else if ((state_q == S_DATA) && bit_end) begin
                par_acc_q <= par_acc_q ^ sampled_bit;
            end

            // perr_q holds the parity verdict until the stop bit reports it
            if (start_go || stop_end) begin
                perr_q <= 1'b0;
            end else if ((state_q == S_PARITY) && bit_end) begin
                perr_q <= sampled_bit != (par_acc_q ^ par_typ);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            valid_q   <= 1'b0;
            par_err_q <= 1'b0;
            stp_err_q <= 1'b0;
        end else begin
            valid_q   <= stop_end && sampled_bit && !perr_q;
            par_err_q <= stop_end && perr_q && !is_break;
            stp_err_q <= stop_end && !sampled_bit && !is_break;
        end
    end

`ifdef UART_RX_BREAK_DET_EN
    logic              zero_q;
    logic              brk_wait_q;
    logic              break_q;
    logic [PWIDTH-1:0] high_cnt_q;

    assign start_ok  = !brk_wait_q;
    assign is_break  = zero_q && !sampled_bit;
    assign break_det = break_q;

    // After a break the line must sit high for a full bit time before a new start counts
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            zero_q     <= 1'b0;
            brk_wait_q <= 1'b0;
            break_q    <= 1'b0;
            high_cnt_q <= '0;
        end else begin
            break_q <= stop_end && is_break;

            if (start_go) begin
                zero_q <= 1'b1;
            end else if (((state_q == S_DATA) || (state_q == S_PARITY)) && bit_end && sampled_bit) begin
                zero_q <= 1'b0;
            end

            if (stop_end && is_break) begin
                brk_wait_q <= 1'b1;
                high_cnt_q <= '0;
            end else if (brk_wait_q) begin
                if (!rx_in) begin
                    high_cnt_q <= '0;
                end else if (high_cnt_q == prescale_q - PWIDTH'(1)) begin
                    brk_wait_q <= 1'b0;
                    high_cnt_q <= '0;
                end else begin
                    high_cnt_q <= high_cnt_q + PWIDTH'(1);
                end
            end
        end
    end
`else
    assign start_ok  = 1'b1;
    assign is_break  = 1'b0;
    assign break_det = 1'b0;
`endif

    assign edge_count  = edge_q;
    assign busy        = (state_q != S_IDLE);
    assign dat_samp_en = (state_q != S_IDLE);
    assign deser_en    = deser_d;
    assign strt_glitch = glitch_d;
    assign data_valid  = valid_q;
    assign par_err     = par_err_q;
    assign stp_err     = stp_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl; an ideal one-cycle-latency sampler feeds sampled_bit.
module tb_uart_rx_ctrl;

    localparam int PW = 6;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          rx_in = 1'b1;
    logic [PW-1:0] prescale = PW'(8);
    logic          par_en = 1'b0;
    logic          par_typ = 1'b0;
    logic          sampled_bit = 1'b1;
    logic [PW-1:0] edge_count;
    logic          dat_samp_en, deser_en, data_valid, par_err, stp_err;
    logic          strt_glitch, busy, break_det;

    uart_rx_ctrl #(.PWIDTH(PW), .DATA_WIDTH(8)) dut (
        .clk         (clk),
        .rst         (rst),
        .rx_in       (rx_in),
        .prescale    (prescale),
        .par_en      (par_en),
        .par_typ     (par_typ),
        .sampled_bit (sampled_bit),
        .edge_count  (edge_count),
        .dat_samp_en (dat_samp_en),
        .deser_en    (deser_en),
        .data_valid  (data_valid),
        .par_err     (par_err),
        .stp_err     (stp_err),
        .strt_glitch (strt_glitch),
        .busy        (busy),
        .break_det   (break_det)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_deser = 0, n_valid = 0, n_perr = 0, n_serr = 0, n_glitch = 0, n_break = 0, n_busy = 0;
    int valid_cyc = 0, glitch_edge = 0;
    logic [7:0] cap = 8'h00;

    always @(negedge clk) begin
        if (deser_en) begin
            n_deser++;
            cap = {sampled_bit, cap[7:1]};
        end
        if (data_valid) begin
            n_valid++;
            valid_cyc = cyc;
        end
        if (par_err) n_perr++;
        if (stp_err) n_serr++;
        if (break_det) n_break++;
        if (busy) n_busy++;
        if (strt_glitch) begin
            n_glitch++;
            glitch_edge = int'(edge_count);
        end
    end

    int errs = 0, checks = 0;
    int b_deser, b_valid, b_perr, b_serr, b_glitch, b_break, b_busy;
    int start_cyc = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic snap();
        b_deser  = n_deser;
        b_valid  = n_valid;
        b_perr   = n_perr;
        b_serr   = n_serr;
        b_glitch = n_glitch;
        b_break  = n_break;
        b_busy   = n_busy;
    endtask

    // sampled_bit follows rx_in by one clock, matching the FSM's view of bit windows
    task automatic step(input logic v);
        @(posedge clk);
        #1;
        sampled_bit = rx_in;
        rx_in       = v;
    endtask

    task automatic hold(input logic v, input int n);
        for (int i = 0; i < n; i++) step(v);
    endtask

    task automatic send_frame(input logic [7:0] data, input logic pbit, input logic sbit, input int tail);
        int p;
        p = int'(prescale);
        step(1'b0);
        start_cyc = cyc;
        hold(1'b0, p - 1);
        for (int i = 0; i < 8; i++) hold(data[i], p);
        if (par_en) hold(pbit, p);
        hold(sbit, p);
        hold(1'b1, tail);
    endtask

    initial begin
        logic [7:0] part;

        hold(1'b1, 3);
        check_eq("reset_flags", {busy, dat_samp_en, deser_en, data_valid, par_err, stp_err, strt_glitch, break_det}, 0);
        check_eq("reset_edge", edge_count, 0);
        rst = 1'b1;
        hold(1'b1, 3);

        // 0xA5, prescale 8, no parity
        snap();
        send_frame(8'hA5, 1'b0, 1'b1, 4);
        check_eq("a5_deser_cnt", n_deser - b_deser, 8);
        check_eq("a5_bits", cap, 8'hA5);
        check_eq("a5_valid", n_valid - b_valid, 1);
        check_eq("a5_latency", valid_cyc - start_cyc, 81);
        check_eq("a5_errs", (n_perr - b_perr) + (n_serr - b_serr), 0);
        check_eq("a5_busy_cycles", n_busy - b_busy, 80);

        // prescale 16, even parity good then bad, then odd parity good
        prescale = PW'(16);
        par_en   = 1'b1;
        par_typ  = 1'b0;
        snap();
        send_frame(8'h07, 1'b1, 1'b1, 4);
        check_eq("even_ok_valid", n_valid - b_valid, 1);
        check_eq("even_ok_perr", n_perr - b_perr, 0);
        check_eq("even_ok_bits", cap, 8'h07);
        snap();
        send_frame(8'h07, 1'b0, 1'b1, 4);
        check_eq("even_bad_perr", n_perr - b_perr, 1);
        check_eq("even_bad_valid", n_valid - b_valid, 0);
        par_typ = 1'b1;
        snap();
        send_frame(8'h07, 1'b0, 1'b1, 4);
        check_eq("odd_ok_valid", n_valid - b_valid, 1);
        check_eq("odd_ok_perr", n_perr - b_perr, 0);
        par_en   = 1'b0;
        par_typ  = 1'b0;
        prescale = PW'(8);

        // start glitch: 3 low clocks
        snap();
        hold(1'b0, 3);
        hold(1'b1, 12);
        check_eq("glitch_cnt", n_glitch - b_glitch, 1);
        check_eq("glitch_edge", glitch_edge, 7);
        check_eq("glitch_deser", n_deser - b_deser, 0);
        check_eq("glitch_busy_cycles", n_busy - b_busy, 8);

        // stop error followed by a back-to-back good frame
        snap();
        send_frame(8'h3C, 1'b0, 1'b0, 1);
        send_frame(8'hC3, 1'b0, 1'b1, 4);
        check_eq("b2b_stp_err", n_serr - b_serr, 1);
        check_eq("b2b_valid", n_valid - b_valid, 1);
        check_eq("b2b_bits", cap, 8'hC3);
        check_eq("b2b_deser", n_deser - b_deser, 16);

        // async reset during data bit 4
        snap();
        part = 8'h96;
        step(1'b0);
        hold(1'b0, 7);
        for (int i = 0; i < 4; i++) hold(part[i], 8);
        hold(part[4], 3);
        #2;
        rst = 1'b0;
        #1;
        check_eq("midrst_flags", {busy, dat_samp_en, deser_en, data_valid, par_err, stp_err, strt_glitch, break_det}, 0);
        check_eq("midrst_edge", edge_count, 0);
        hold(1'b1, 3);
        rst = 1'b1;
        hold(1'b1, 5);
        check_eq("midrst_deser", n_deser - b_deser, 4);
        check_eq("midrst_no_flags", (n_valid - b_valid) + (n_perr - b_perr) + (n_serr - b_serr) + (n_glitch - b_glitch), 0);
        snap();
        send_frame(8'h5A, 1'b0, 1'b1, 4);
        check_eq("after_rst_valid", n_valid - b_valid, 1);
        check_eq("after_rst_bits", cap, 8'h5A);

        // prescale below 8 keeps the block idle
        prescale = PW'(5);
        snap();
        hold(1'b0, 12);
        hold(1'b1, 3);
        check_eq("low_prescale_busy", n_busy - b_busy, 0);
        prescale = PW'(8);
        hold(1'b1, 2);

        // ten bit-times low
        snap();
        send_frame(8'h00, 1'b0, 1'b0, 4);
`ifdef UART_RX_BREAK_DET_EN
        check_eq("break_det", n_break - b_break, 1);
        check_eq("break_stp_err", n_serr - b_serr, 0);
`else
        check_eq("break_det", n_break - b_break, 0);
        check_eq("break_stp_err", n_serr - b_serr, 1);
`endif
        snap();
        hold(1'b0, 3);
        hold(1'b1, 12);
`ifdef UART_RX_BREAK_DET_EN
        check_eq("break_early_start", n_glitch - b_glitch, 0);
`else
        check_eq("break_early_start", n_glitch - b_glitch, 1);
`endif
        send_frame(8'h81, 1'b0, 1'b1, 4);
        check_eq("post_break_valid", n_valid - b_valid, 1);
        check_eq("post_break_bits", cap, 8'h81);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
